// File: rtl/rx_iq_pkg.sv
// Shared sizing defaults, counter width, sample-set record and a saturating
// increment helper for the RX I/Q buffer.
package rx_iq_pkg;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned SAMPLE_W = 32;
  localparam int unsigned CNT_W    = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] rx1_i;
    logic signed [SAMPLE_W-1:0] rx1_q;
    logic signed [SAMPLE_W-1:0] rx2_i;
    logic signed [SAMPLE_W-1:0] rx2_q;
  } iq_set_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/rx_iq_ram.sv
// Simple dual-port storage for packed sample sets: one synchronous write
// port and one registered read port, no reset on the array.
module rx_iq_ram #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 128
) (
  input  logic                     clk_in,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Same-address write and read on one edge returns the old word.
  always_ff @(posedge clk_in) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/rx_iq_buffer.sv
// FIFO of DDC sample sets: one write per IQ_valid strobe, pop on rd_req with
// one-cycle latency, drop/underrun accounting and a flush that wins over both.
module rx_iq_buffer #(
  parameter int unsigned DEPTH    = rx_iq_pkg::DEPTH,
  parameter int unsigned SAMPLE_W = rx_iq_pkg::SAMPLE_W
) (
  input  logic                             clk_in,
  input  logic                             reset,
  input  logic signed [SAMPLE_W-1:0]       RX1_I,
  input  logic signed [SAMPLE_W-1:0]       RX1_Q,
  input  logic signed [SAMPLE_W-1:0]       RX2_I,
  input  logic signed [SAMPLE_W-1:0]       RX2_Q,
  input  logic                             IQ_valid,
  input  logic                             rd_req,
  input  logic                             flush,
  output logic                             rd_valid,
  output logic signed [SAMPLE_W-1:0]       rd_RX1_I,
  output logic signed [SAMPLE_W-1:0]       rd_RX1_Q,
  output logic signed [SAMPLE_W-1:0]       rd_RX2_I,
  output logic signed [SAMPLE_W-1:0]       rd_RX2_Q,
  output logic                             empty,
  output logic                             full,
  output logic [$clog2(DEPTH):0]           level,
  output logic                             overflow,
  output logic [rx_iq_pkg::CNT_W-1:0]      drop_count,
  output logic [rx_iq_pkg::CNT_W-1:0]      underrun_count
);

  import rx_iq_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = 4 * SAMPLE_W;

  logic          iq_valid_d;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          rd_zero;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] wr_word;

  logic wr_event;
  logic pop_ok;
  logic pop_under;
  logic wr_ok;
  logic wr_drop;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  assign wr_event  = IQ_valid & ~iq_valid_d;
  assign pop_ok    = rd_req & ~flush & ~empty;
  assign pop_under = rd_req & ~flush & empty;
  // A pop on a full buffer frees the slot the write lands in.
  assign wr_ok     = wr_event & ~flush & (~full | pop_ok);
  assign wr_drop   = wr_event & ~flush & full & ~pop_ok;

  assign wr_word = {RX1_I, RX1_Q, RX2_I, RX2_Q};

  rx_iq_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DW)
  ) u_ram (
    .clk_in  (clk_in),
    .wr_en   (wr_ok),
    .wr_addr (head),
    .wr_data (wr_word),
    .rd_en   (pop_ok),
    .rd_addr (tail),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      iq_valid_d     <= 1'b0;
      head           <= '0;
      tail           <= '0;
      level          <= '0;
      rd_valid       <= 1'b0;
      rd_zero        <= 1'b1;
      overflow       <= 1'b0;
      drop_count     <= '0;
      underrun_count <= '0;
    end else begin
      iq_valid_d <= IQ_valid;
      if (flush) begin
        head           <= '0;
        tail           <= '0;
        level          <= '0;
        rd_valid       <= 1'b0;
        overflow       <= 1'b0;
        drop_count     <= '0;
        underrun_count <= '0;
      end else begin
        rd_valid <= rd_req;
        if (wr_ok) begin
          head <= head + 1'b1;
        end
        if (pop_ok) begin
          tail <= tail + 1'b1;
        end
        unique case ({wr_ok, pop_ok})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: ;
        endcase
        if (pop_ok) begin
          rd_zero <= 1'b0;
        end else if (pop_under) begin
          rd_zero <= 1'b1;
        end
        if (wr_drop) begin
          overflow   <= 1'b1;
          drop_count <= sat_inc(drop_count);
        end
        if (pop_under) begin
          underrun_count <= sat_inc(underrun_count);
        end
      end
    end
  end

  // The RAM read register has no reset; rd_zero masks it after reset and
  // after an underrun pop, and holds the last popped set otherwise.
  always_comb begin
    {rd_RX1_I, rd_RX1_Q, rd_RX2_I, rd_RX2_Q} = rd_zero ? '0 : ram_q;
  end

endmodule
